// File: rtl/mem_bridge_seq.sv
// mem_bridge_seq: clocked main-bus/memory-data bridge with wait states, turnaround dead cycle and abort
module mem_bridge_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int WAIT_STATES = 1,
  parameter bit TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] MainBus_in,
  output logic [DATA_WIDTH-1:0] MainBus_out,
  output logic                  MainBus_oe,
  input  logic [DATA_WIDTH-1:0] MEMDATA_in,
  output logic [DATA_WIDTH-1:0] MEMDATA_out,
  output logic                  MEMDATA_oe,
  input  logic                  MemBridge_Assert,
  input  logic                  MemBridge_Direction,
  output logic                  MemBridge_Busy,
  output logic                  MemBridge_Done,
  output logic                  MemBridge_Abort
);
  typedef enum logic [2:0] {IDLE, TURN, XFER, HOLD, RELEASE} stateE;
  stateE state, nextState;
  logic [3:0] cnt;
  logic dirQ, lastDir, doneQ, abortQ, finish;
  logic [DATA_WIDTH-1:0] wrQ, rdQ;
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : gBadWait
    $error("mem_bridge_seq: WAIT_STATES must be within 0..15");
  end
  assign finish = state == XFER && MemBridge_Assert && cnt == 4'd0;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (MemBridge_Assert) nextState = (TURNAROUND && MemBridge_Direction != lastDir) ? TURN : XFER;
      TURN:    nextState = MemBridge_Assert ? XFER : IDLE;
      XFER:    nextState = !MemBridge_Assert ? IDLE : finish ? HOLD : XFER;
      HOLD:    nextState = MemBridge_Assert ? HOLD : RELEASE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      dirQ <= 1'b0;
      lastDir <= 1'b0;
      doneQ <= 1'b0;
      abortQ <= 1'b0;
      wrQ <= '0;
      rdQ <= '0;
    end else begin
      doneQ <= finish;
      abortQ <= (state == TURN || state == XFER) && !MemBridge_Assert;
      cnt <= state == XFER ? cnt - 4'd1 : 4'(WAIT_STATES);
      if (state == IDLE && MemBridge_Assert) begin
        dirQ <= MemBridge_Direction;
        if (MemBridge_Direction) wrQ <= MainBus_in;
      end
      if (finish) begin
        lastDir <= dirQ;
        if (!dirQ) rdQ <= MEMDATA_in;
      end
    end
  end
  always_comb begin
    MainBus_oe = state == HOLD && !dirQ;
    MEMDATA_oe = state == XFER && dirQ;
    MainBus_out = MainBus_oe ? rdQ : '0;
    MEMDATA_out = MEMDATA_oe ? wrQ : '0;
    MemBridge_Busy = state != IDLE;
    MemBridge_Done = doneQ;
    MemBridge_Abort = abortQ;
  end
endmodule

// File: tb/tb_mem_bridge_seq.sv
// tb_mem_bridge_seq: directed and random transfers checked cycle by cycle against a transaction-level model
module tb_mem_bridge_seq;
  localparam int DW = 8;
  localparam int WS = 1;
  localparam bit TA = 1;
  localparam int VW = 2 * DW + 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] mbIn = '0, mdIn = '0;
  logic assertReq = 1'b0, dir = 1'b0;
  logic [DW-1:0] MainBus_out, MEMDATA_out;
  logic MainBus_oe, MEMDATA_oe, Busy, Done, Abort;
  int checks = 0, errors = 0;
  logic lastDir = 1'b0;
  bit inRelease = 1'b0;
  mem_bridge_seq #(.DATA_WIDTH(DW), .WAIT_STATES(WS), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n),
    .MainBus_in(mbIn), .MainBus_out(MainBus_out), .MainBus_oe(MainBus_oe),
    .MEMDATA_in(mdIn), .MEMDATA_out(MEMDATA_out), .MEMDATA_oe(MEMDATA_oe),
    .MemBridge_Assert(assertReq), .MemBridge_Direction(dir),
    .MemBridge_Busy(Busy), .MemBridge_Done(Done), .MemBridge_Abort(Abort)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    checks++;
    assert (!(MainBus_oe && MEMDATA_oe) && !(Done && Abort)) else begin
      errors++;
      $error("FAIL exclusive observed oe=%b%b done/abort=%b%b expected no pair both high", MainBus_oe, MEMDATA_oe, Done, Abort);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic checkOut(input string tag, input logic busy, input logic mbOe, input logic [DW-1:0] mbOut,
                          input logic mdOe, input logic [DW-1:0] mdOut, input logic done, input logic abort);
    logic [VW-1:0] o, e;
    o = {Busy, MainBus_oe, MainBus_out, MEMDATA_oe, MEMDATA_out, Done, Abort};
    e = {busy, mbOe, mbOut, mdOe, mdOut, done, abort};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (busy,mbOe,mbOut,mdOe,mdOut,done,abort)", tag, o, e);
    end
  endtask
  task automatic xfer(input logic wr, input logic [DW-1:0] data, input logic [DW-1:0] memData,
                      input int abortAt, input int holdLen, input bit b2b, input bit rstInHold);
    bit turn;
    int n;
    logic [DW-1:0] z, busData;
    z = '0;
    turn = TA && (wr != lastDir);
    n = int'(turn) + WS + 1;
    busData = wr ? z : memData;
    assertReq = 1'b1;
    dir = wr;
    mbIn = data;
    mdIn = DW'($urandom);
    if (inRelease) begin
      tick;
      checkOut("idle_gap", 0, 0, z, 0, z, 0, 0);
    end
    tick;
    for (int i = 0; i < n; i++) begin
      if (i < int'(turn)) checkOut("turn", 1, 0, z, 0, z, 0, 0);
      else checkOut("xfer", 1, 0, z, wr, wr ? data : z, 0, 0);
      dir = 1'($urandom);
      mbIn = DW'($urandom);
      mdIn = (i == n - 1) ? memData : DW'($urandom);
      if (i == abortAt) begin
        assertReq = 1'b0;
        tick;
        checkOut("abort", 0, 0, z, 0, z, 0, 1);
        inRelease = 1'b0;
        return;
      end
      tick;
    end
    lastDir = wr;
    checkOut("done", 1, !wr, busData, 0, z, 1, 0);
    mdIn = DW'($urandom);
    for (int i = 1; i < holdLen; i++) begin
      tick;
      checkOut("hold", 1, !wr, busData, 0, z, 0, 0);
    end
    if (rstInHold) begin
      rst_n = 1'b0;
      tick;
      checkOut("reset_hold", 0, 0, z, 0, z, 0, 0);
      rst_n = 1'b1;
      assertReq = 1'b0;
      lastDir = 1'b0;
      inRelease = 1'b0;
      return;
    end
    assertReq = 1'b0;
    tick;
    checkOut("release", 1, 0, z, 0, z, 0, 0);
    inRelease = 1'b1;
    if (!b2b) begin
      tick;
      checkOut("idle", 0, 0, z, 0, z, 0, 0);
      inRelease = 1'b0;
    end
  endtask
  initial begin
    tick;
    tick;
    checkOut("reset_state", 0, 0, '0, 0, '0, 0, 0);
    rst_n = 1'b1;
    xfer(1'b0, 8'h00, 8'hA5, -1, 3, 1'b0, 1'b0);
    xfer(1'b1, 8'h3C, 8'h00, -1, 2, 1'b1, 1'b0);
    xfer(1'b1, 8'hC3, 8'h00, -1, 1, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'h5A, -1, 1, 1'b1, 1'b0);
    xfer(1'b1, 8'h77, 8'h00, 2, 1, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'h96, -1, 2, 1'b0, 1'b0);
    xfer(1'b1, 8'h11, 8'h00, 0, 1, 1'b0, 1'b0);
    xfer(1'b1, 8'hE1, 8'h00, -1, 2, 1'b0, 1'b1);
    xfer(1'b1, 8'h1E, 8'h00, -1, 1, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'h69, -1, 2, 1'b0, 1'b1);
    for (int k = 0; k < 1000; k++)
      xfer(1'($urandom), DW'($urandom), DW'($urandom),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1,
           int'($urandom_range(1, 3)), 1'($urandom), $urandom_range(0, 49) == 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bridge_seq.md
Name: mem_bridge_seq

Overview:
Parametrised, clocked successor to the combinational main-bus/memory-data bridge. It moves one word per request between the CPU main bus and the memory data bus, in either direction. It adds programmable memory wait states, a read-data holding latch, an optional dead cycle on bus turnaround, and abort handling. Tristate pads sit at top level; this block only produces data and output-enable pairs.

Parameters:
DATA_WIDTH, 8, width of both buses
WAIT_STATES, 1, extra memory cycles per transfer (0..15); the transfer phase lasts WAIT_STATES+1 cycles
TURNAROUND, 1, 1 = insert one dead cycle when direction differs from the previous completed transfer

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
MainBus_in  in  DATA_WIDTH  main bus sampled value
MainBus_out  out  DATA_WIDTH  main bus drive value
MainBus_oe  out  1  main bus output enable
MEMDATA_in  in  DATA_WIDTH  memory data sampled value
MEMDATA_out  out  DATA_WIDTH  memory data drive value
MEMDATA_oe  out  1  memory data output enable
MemBridge_Assert  in  1  transfer request, level, held for the whole transfer
MemBridge_Direction  in  1  1 = write (main->mem), 0 = read (mem->main)
MemBridge_Busy  out  1  high in any state other than IDLE
MemBridge_Done  out  1  one-cycle pulse when a transfer completes
MemBridge_Abort  out  1  one-cycle pulse when Assert drops before completion

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; all outputs 0; data registers 0; last_dir=0 (read). Reset wins over every other event, including mid-transfer. Both enables must be 0 in the cycle after the reset edge.
- States: IDLE, TURN, XFER, HOLD, RELEASE.
- IDLE:
  - On an edge with Assert=1, latch dir_q=Direction.
  - For a write, also latch wr_q=MainBus_in.
  - If TURNAROUND=1 and dir_q != last_dir, go to TURN; otherwise go to XFER with cnt=WAIT_STATES.
- TURN: one cycle with both enables 0, then XFER with cnt=WAIT_STATES.
- XFER:
  - Write: MEMDATA_oe=1, MEMDATA_out=wr_q.
  - Read: both enables 0.
  - cnt decrements each edge.
  - At the edge where cnt==0: a read captures rd_q=MEMDATA_in; last_dir<=dir_q; go to HOLD; Done=1 for the following cycle only.
- HOLD:
  - Read: MainBus_oe=1, MainBus_out=rd_q.
  - Write: both enables 0.
  - Stay while Assert=1. On an edge with Assert=0, go to RELEASE.
- RELEASE: one cycle with both enables 0, then IDLE. This guarantees a dead cycle before a back-to-back request can start.
- Abort: Assert=0 sampled at an edge while in TURN or XFER:
  - go to IDLE; enables drop in the next cycle;
  - Abort=1 for one cycle; no Done;
  - rd_q and last_dir unchanged.
- Direction is sampled only in IDLE. Changes during TURN, XFER or HOLD are ignored.
- Invariant: MainBus_oe and MEMDATA_oe are never 1 in the same cycle.
- Outputs are registered (state decode only, no input-to-output combinational path).
- Done and Abort are never high together.
- cnt width is 4 bits; WAIT_STATES outside 0..15 is illegal. Elaboration check is required.
- Latency, Assert sampled at edge E0, no turnaround: Done high in the cycle after edge E0+WAIT_STATES+1. A read drives MainBus from that same cycle.

Test Plan:
- WAIT_STATES=1, TURNAROUND=1, after reset: read, MEMDATA_in=0xA5 -> no TURN (last_dir=0); MEMDATA_oe stays 0; XFER 2 cycles; Done pulse; MainBus_oe=1 with 0xA5 until Assert drops; RELEASE; then IDLE.
- Same config, write 0x3C following the read -> 1 TURN cycle with both enables 0; MEMDATA_oe=1 with 0x3C for exactly 2 cycles; Done; enables 0 in HOLD. A second write immediately after -> no TURN.
- WAIT_STATES=0 read, then WAIT_STATES=3 read (separate builds) -> Done 1 and 4 cycles after the acceptance edge, respectively.
- Assert dropped in the 2nd XFER cycle of a WAIT_STATES=3 write -> Abort pulse; no Done; MEMDATA_oe low the next cycle; last_dir unchanged (following read has no TURN if last_dir=0).
- rst_n=0 during HOLD of a read -> next cycle all outputs 0, state IDLE, last_dir=0.
- Random back-to-back mixed transfers, 1000 requests -> assertion that both enables are never 1 together; assertion that a RELEASE cycle sits between consecutive transfers; Direction toggled mid-transfer has no effect.
